// File: rtl/flexibit_pkg.sv
// Shared FlexiBit datapath package: accumulator FSM state encoding, default
// widths, and the widening add used by the reduction blocks.
package flexibit_pkg;

   // Reduction FSM: summing beats, or holding a finished result.
   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } acc_state_t;

   // Default geometry for the reduction blocks.
   localparam int DEF_BITWIDTH  = 16;
   localparam int DEF_ACC_WIDTH = 32;
   localparam int DEF_MAX_LEN   = 64;

   // Widest accumulator the shared widening add supports.
   localparam int ADD_MAX_W = 64;

   // Unsigned add that keeps the carry: operands are zero-padded to
   // ADD_MAX_W bits, so for a W-bit accumulator bit W of the result is the
   // carry out of the W-bit sum.
   function automatic logic [ADD_MAX_W:0] add_wide(
      input logic [ADD_MAX_W-1:0] a,
      input logic [ADD_MAX_W-1:0] b
   );
      add_wide = {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/acc_adder_sat.sv
// Combinational accumulate step: acc + zero-extended operand, with carry out
// and optional clamp to all-ones on carry. Requires
// BITWIDTH <= ACC_WIDTH <= flexibit_pkg::ADD_MAX_W.
module acc_adder_sat
   import flexibit_pkg::*;
#(
   parameter int BITWIDTH  = DEF_BITWIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter bit SATURATE  = 1'b0
) (
   input  logic [ACC_WIDTH-1:0] acc,
   input  logic [BITWIDTH-1:0]  operand,
   output logic [ACC_WIDTH-1:0] sum,
   output logic                 carry
);

   logic [ADD_MAX_W-1:0] acc_pad_s;
   logic [ADD_MAX_W-1:0] op_pad_s;
   logic [ADD_MAX_W:0]   wide_s;

   // Zero-extend both addends into the shared adder width.
   always_comb begin
      acc_pad_s                  = {ADD_MAX_W{1'b0}};
      op_pad_s                   = {ADD_MAX_W{1'b0}};
      acc_pad_s[ACC_WIDTH-1:0]   = acc;
      op_pad_s[BITWIDTH-1:0]     = operand;
   end

   assign wide_s = add_wide(acc_pad_s, op_pad_s);

   // Bits above the carry are always zero for in-range operands.
   generate
      if (ACC_WIDTH < ADD_MAX_W) begin : g_hi_bits
         logic unused_hi_s;
         assign unused_hi_s = |wide_s[ADD_MAX_W:ACC_WIDTH+1];
      end
   endgenerate

   // Pick the wrapped or clamped result and expose the carry.
   always_comb begin
      carry = wide_s[ACC_WIDTH];
      if (SATURATE && wide_s[ACC_WIDTH]) begin
         sum = {ACC_WIDTH{1'b1}};
      end else begin
         sum = wide_s[ACC_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/stream_accumulator.sv
// Stream accumulator: sums unsigned operand beats until a last beat (or
// MAX_LEN beats) is accepted, then presents the sum on a valid/ready output.
// Optional build macro ACC_SATURATE_EN: clamp the accumulator to all-ones on
// carry out instead of wrapping modulo 2^ACC_WIDTH.
module stream_accumulator
   import flexibit_pkg::*;
#(
   parameter  int BITWIDTH  = DEF_BITWIDTH,
   parameter  int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter  int MAX_LEN   = DEF_MAX_LEN,
   localparam int CNT_W     = $clog2(MAX_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BITWIDTH-1:0]  in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]     out_count,
   output logic                 out_overflow,
   output logic                 out_truncated
);

`ifdef ACC_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   acc_state_t           state_r;
   acc_state_t           state_next_s;
   logic [ACC_WIDTH-1:0] acc_r;
   logic [ACC_WIDTH-1:0] acc_next_s;
   logic [CNT_W-1:0]     count_r;
   logic [CNT_W-1:0]     count_next_s;
   logic [CNT_W-1:0]     count_inc_s;
   logic                 ovf_r;
   logic                 ovf_next_s;
   logic                 trunc_r;
   logic                 trunc_next_s;
   logic                 in_ready_r;
   logic                 out_valid_r;
   logic                 accept_s;
   logic                 release_s;
   logic                 hit_max_s;
   logic [ACC_WIDTH-1:0] sum_s;
   logic                 carry_s;

   acc_adder_sat #(
      .BITWIDTH  (BITWIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .SATURATE  (SAT_EN)
   ) u_adder (
      .acc     (acc_r),
      .operand (in_data),
      .sum     (sum_s),
      .carry   (carry_s)
   );

   // Handshake qualifiers and the beat-count limit test.
   always_comb begin
      accept_s    = in_valid && in_ready_r && (state_r == ACCUM);
      release_s   = out_valid_r && out_ready && (state_r == DONE);
      count_inc_s = count_r + CNT_ONE;
      hit_max_s   = (count_inc_s == CNT_MAX);
   end

   // Next-state and datapath update for the accumulate/present FSM.
   always_comb begin
      state_next_s = state_r;
      acc_next_s   = acc_r;
      count_next_s = count_r;
      ovf_next_s   = ovf_r;
      trunc_next_s = trunc_r;
      case (state_r)
         ACCUM: begin
            if (accept_s) begin
               acc_next_s   = sum_s;
               count_next_s = count_inc_s;
               ovf_next_s   = ovf_r | carry_s;
               if (in_last || hit_max_s) begin
                  state_next_s = DONE;
                  trunc_next_s = hit_max_s && !in_last;
               end else begin
                  state_next_s = ACCUM;
               end
            end else begin
               state_next_s = ACCUM;
            end
         end
         DONE: begin
            if (release_s) begin
               state_next_s = ACCUM;
               acc_next_s   = {ACC_WIDTH{1'b0}};
               count_next_s = CNT_ZERO;
               ovf_next_s   = 1'b0;
               trunc_next_s = 1'b0;
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = ACCUM;
            acc_next_s   = {ACC_WIDTH{1'b0}};
            count_next_s = CNT_ZERO;
            ovf_next_s   = 1'b0;
            trunc_next_s = 1'b0;
         end
      endcase
   end

   // State, accumulator and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ACCUM;
         acc_r       <= {ACC_WIDTH{1'b0}};
         count_r     <= CNT_ZERO;
         ovf_r       <= 1'b0;
         trunc_r     <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         acc_r       <= acc_next_s;
         count_r     <= count_next_s;
         ovf_r       <= ovf_next_s;
         trunc_r     <= trunc_next_s;
         in_ready_r  <= (state_next_s == ACCUM);
         out_valid_r <= (state_next_s == DONE);
      end
   end

   // The accumulator registers are frozen in DONE, so they serve directly
   // as the held result.
   assign in_ready      = in_ready_r;
   assign out_valid     = out_valid_r;
   assign out_data      = acc_r;
   assign out_count     = count_r;
   assign out_overflow  = ovf_r;
   assign out_truncated = trunc_r;

endmodule

// File: tb/tb_stream_accumulator.sv
// Scoreboard bench for stream_accumulator (BITWIDTH 16, ACC_WIDTH 16,
// MAX_LEN 4). Expected results are queued as each vector closes in the
// bench model and compared when the DUT presents its result.
module tb_stream_accumulator;

   localparam int BW = 16;
   localparam int AW = 16;
   localparam int ML = 4;
   localparam int CW = $clog2(ML + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_data;
   logic [CW-1:0] out_count;
   logic          out_overflow;
   logic          out_truncated;

   typedef struct packed {
      logic [AW-1:0] data;
      logic [CW-1:0] count;
      logic          ovf;
      logic          trunc;
   } exp_t;

   exp_t          sb_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [AW-1:0] m_acc;
   int            m_count;
   logic          m_ovf;

   stream_accumulator #(
      .BITWIDTH  (BW),
      .ACC_WIDTH (AW),
      .MAX_LEN   (ML)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_count     (out_count),
      .out_overflow  (out_overflow),
      .out_truncated (out_truncated)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_acc   = '0;
      m_count = 0;
      m_ovf   = 1'b0;
   endtask

   // Reference accumulate step; pushes the expected result when a vector closes.
   task automatic model_accept(input logic [BW-1:0] d, input logic l, output bit closed);
      logic [AW:0] s;
      exp_t        e;
      s = {1'b0, m_acc} + {1'b0, d};
      if (s[AW]) begin
         m_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
         m_acc = '1;
`else
         m_acc = s[AW-1:0];
`endif
      end else begin
         m_acc = s[AW-1:0];
      end
      m_count++;
      closed = l || (m_count == ML);
      if (closed) begin
         e.data  = m_acc;
         e.count = m_count[CW-1:0];
         e.ovf   = m_ovf;
         e.trunc = !l && (m_count == ML);
         sb_q.push_back(e);
         model_clear();
      end
   endtask

   // Drive one beat starting at a falling edge; returns at the falling edge after acceptance.
   task automatic send_beat(input logic [BW-1:0] d, input logic l);
      int waits;
      bit closed;
      waits    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (in_ready !== 1'b1 && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      if (in_ready !== 1'b1) begin
         check_eq("beat_accept_timeout", 32'd0, 32'd1);
      end else begin
         model_accept(d, l, closed);
         @(negedge clk);
         check_eq("out_valid_after_accept", out_valid, closed);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while ((sb_q.size() != 0 || out_valid) && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (sb_q.size() != 0 || out_valid) check_eq("drain_timeout", 32'd0, 32'd1);
   endtask

   // Result monitor: every cycle a result is shown it must match the queue head.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && out_valid) begin
         check_eq("in_ready_low_in_done", in_ready, 32'd0);
         if (sb_q.size() == 0) begin
            check_eq("unexpected_result", 32'd1, 32'd0);
         end else begin
            e = sb_q[0];
            check_eq("out_data", out_data, e.data);
            check_eq("out_count", out_count, e.count);
            check_eq("out_overflow", out_overflow, e.ovf);
            check_eq("out_truncated", out_truncated, e.trunc);
            if (out_ready) void'(sb_q.pop_front());
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [BW-1:0] rnd;
      int            len;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      model_clear();
      #1;
      check_eq("reset_out_valid", out_valid, 32'd0);
      check_eq("reset_in_ready", in_ready, 32'd0);
      repeat (2) @(negedge clk);
      check_eq("reset_in_ready_held", in_ready, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("in_ready_after_release", in_ready, 32'd1);
      check_eq("out_valid_after_release", out_valid, 32'd0);

      // Basic three-beat vector.
      send_beat(16'd3, 1'b0);
      send_beat(16'd5, 1'b0);
      send_beat(16'd7, 1'b1);
      wait_idle();

      // Single-beat vector.
      send_beat(16'h1234, 1'b1);
      wait_idle();

      // Carry out of the accumulator.
      send_beat(16'hFFFF, 1'b0);
      send_beat(16'h0002, 1'b1);
      wait_idle();

      // Last beat landing exactly on MAX_LEN is not truncated.
      send_beat(16'd1, 1'b0);
      send_beat(16'd2, 1'b0);
      send_beat(16'd3, 1'b0);
      send_beat(16'd4, 1'b1);
      wait_idle();

      // Five beats without last: force-close at four, fifth starts next vector.
      for (int i = 0; i < 5; i++) send_beat(16'd1, 1'b0);
      send_beat(16'd2, 1'b1);
      wait_idle();

      // Back-pressure in DONE with a beat waiting.
      out_ready = 1'b0;
      send_beat(16'd10, 1'b0);
      send_beat(16'd20, 1'b1);
      fork
         send_beat(16'd100, 1'b0);
         begin
            repeat (10) begin
               @(negedge clk);
               #1;
               check_eq("hold_in_ready", in_ready, 32'd0);
               check_eq("hold_out_valid", out_valid, 32'd1);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      send_beat(16'd1, 1'b1);
      wait_idle();

      // Reset mid-vector discards the partial sum.
      send_beat(16'd3, 1'b0);
      send_beat(16'd4, 1'b0);
      rst_n = 1'b0;
      model_clear();
      #1;
      check_eq("midreset_out_valid", out_valid, 32'd0);
      check_eq("midreset_in_ready", in_ready, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_eq("postreset_out_valid", out_valid, 32'd0);
      end
      check_eq("postreset_in_ready", in_ready, 32'd1);
      send_beat(16'd9, 1'b1);
      wait_idle();

      // A few random vectors of length 1..MAX_LEN.
      for (int v = 0; v < 6; v++) begin
         len = $urandom_range(1, ML);
         for (int b = 0; b < len; b++) begin
            rnd = BW'($urandom);
            send_beat(rnd, (b == len - 1));
         end
      end
      wait_idle();

      check_eq("scoreboard_empty", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
